// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control path.
//   state_e      : control FSM state encoding; the display/split logic also
//                  imports it to observe the current mode.
//   OUT_*        : {init_regs, count_enabled} output pattern for each state.
//   decode_outs  : maps a state to its output pattern. Illegal encodings
//                  report the IDLE pattern, matching where they recover to.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_COUNTING = 2'b01,
        ST_PAUSED   = 2'b10
    } state_e;

    // {init_regs, count_enabled}
    localparam logic [1:0] OUT_IDLE     = 2'b10;
    localparam logic [1:0] OUT_COUNTING = 2'b01;
    localparam logic [1:0] OUT_PAUSED   = 2'b00;

    function automatic logic [1:0] decode_outs(input state_e st);
        logic [1:0] outs;
        case (st)
            ST_IDLE:     outs = OUT_IDLE;
            ST_COUNTING: outs = OUT_COUNTING;
            ST_PAUSED:   outs = OUT_PAUSED;
            default:     outs = OUT_IDLE;
        endcase
        return outs;
    endfunction

endpackage

// File: rtl/stopwatch_ctl.sv
// Stopwatch control FSM.
// Takes single-cycle start/stop (trig) and split/clear (split) pulses from the
// debounced button front end and produces level controls for the counters.
// Ports:
//   clk           in  : system clock, rising edge
//   reset         in  : synchronous active-high reset, forces IDLE
//   trig          in  : start / pause / resume pulse
//   split         in  : clear pulse (only acts while paused)
//   init_regs     out : high in IDLE, holds the counters at zero
//   count_enabled out : high in COUNTING, lets the counters advance
// Outputs are Moore, decoded from the state register only.
module stopwatch_ctl
    import stopwatch_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic trig,
    input  logic split,
    output logic init_regs,
    output logic count_enabled
);

    state_e state_q;
    state_e state_d;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // trig is tested first in every state, so it wins over a same-cycle split.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (trig) state_d = ST_COUNTING;
            end
            ST_COUNTING: begin
                // split here is a display lap function handled elsewhere
                if (trig) state_d = ST_PAUSED;
            end
            ST_PAUSED: begin
                if (trig)       state_d = ST_COUNTING;
                else if (split) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        {init_regs, count_enabled} = decode_outs(state_q);
    end

endmodule

// File: tb/tb_stopwatch_ctl.sv
// Self-checking bench for stopwatch_ctl: a directed walk through the mode
// sequence followed by random reset/trig/split traffic, compared every cycle
// against a behavioural model that tracks "is it running" and "is the time
// cleared" rather than FSM states.
module tb_stopwatch_ctl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic trig = 1'b0;
    logic split = 1'b0;
    logic init_regs;
    logic count_enabled;

    int total = 0;
    int bad = 0;

    // reference model
    bit running;
    bit cleared;

    stopwatch_ctl dut (
        .clk           (clk),
        .reset         (reset),
        .trig          (trig),
        .split         (split),
        .init_regs     (init_regs),
        .count_enabled (count_enabled)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got {init,en}=%b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock with the given inputs, then compare outputs 1ns after the edge.
    task automatic step(input string tag, input bit r, input bit t, input bit s);
        @(negedge clk);
        reset = r;
        trig  = t;
        split = s;
        @(posedge clk);
        if (r) begin
            running = 1'b0;
            cleared = 1'b1;
        end else if (t) begin
            running = !running;
            cleared = 1'b0;
        end else if (s && !running) begin
            cleared = 1'b1;
        end
        #1;
        chk(tag, {init_regs, count_enabled}, {cleared, running});
    endtask

    initial begin
        running = 1'b0;
        cleared = 1'b1;

        // reset and idle hold
        step("reset", 1, 0, 0);
        chk("reset_const", {init_regs, count_enabled}, 2'b10);
        step("idle_hold1", 0, 0, 0);
        step("idle_hold2", 0, 0, 0);
        chk("idle_hold_const", {init_regs, count_enabled}, 2'b10);

        // start, split ignored while counting
        step("start", 0, 1, 0);
        chk("start_const", {init_regs, count_enabled}, 2'b01);
        step("split_counting", 0, 0, 1);
        step("pause", 0, 1, 0);
        step("resume", 0, 1, 0);
        step("pause2", 0, 1, 0);
        step("clear", 0, 0, 1);
        chk("clear_const", {init_regs, count_enabled}, 2'b10);
        step("split_idle", 0, 0, 1);

        // reset from counting, and reset overriding trig
        step("start2", 0, 1, 0);
        step("reset_counting", 1, 0, 0);
        step("after_reset", 0, 0, 0);
        step("reset_with_trig", 1, 1, 0);
        chk("reset_trig_const", {init_regs, count_enabled}, 2'b10);

        // trig priority over split in PAUSED, and held trig acting twice
        step("start3", 0, 1, 0);
        step("pause3", 0, 1, 0);
        step("trig_split_prio", 0, 1, 1);
        chk("prio_const", {init_regs, count_enabled}, 2'b01);
        step("held_trig1", 0, 1, 0);
        step("held_trig2", 0, 1, 0);
        chk("held_const", {init_regs, count_enabled}, 2'b01);

        // trig+split in IDLE and COUNTING
        step("reset4", 1, 0, 0);
        step("idle_trig_split", 0, 1, 1);
        step("cnt_trig_split", 0, 1, 1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step("random", ($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1);
        end

        @(negedge clk);
        reset = 1'b0;
        trig  = 1'b0;
        split = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
